mem_arbiter: RTL and testbench

- Shares the single 8-bit-wide unified RAM port between instruction fetch (IF) and load/store (MEM).
- Serialises each request into byte transfers and reassembles read data.
- Raises per-stage stall requests to the pipeline stall controller while a requester is waiting.
- Sits between the IF/MEM stages and the external RAM.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one 8-bit RAM port between instruction fetch and load/store.
// Requests are serialised into byte transfers; load/store wins ties.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [31:0]       if_inst,
    output logic              if_done,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic [31:0]       buf_q, buf_nxt;
    logic [2:0]        n_q, n_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] ram_a_nxt;
    logic [7:0]        ram_dout_nxt;
    logic              ram_wr_nxt;
    logic [31:0]       if_inst_nxt, mem_rdata_nxt;
    logic              if_done_nxt, mem_done_nxt;
    logic              sample, grant_mem, grant_if;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // No new grant in a cycle where a done pulse is visible: the requester is still dropping req.
    assign sample    = ~if_done & ~mem_done;
    assign grant_mem = sample & mem_req;
    assign grant_if  = sample & ~mem_req & if_req;

    assign stallreq_if  = if_req & ~if_done;
    assign stallreq_mem = mem_req & ~mem_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            n_q       <= '0;
            cnt       <= '0;
            ram_a     <= '0;
            ram_dout  <= '0;
            ram_wr    <= 1'b0;
            if_inst   <= '0;
            if_done   <= 1'b0;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            buf_q     <= buf_nxt;
            n_q       <= n_nxt;
            cnt       <= cnt_nxt;
            ram_a     <= ram_a_nxt;
            ram_dout  <= ram_dout_nxt;
            ram_wr    <= ram_wr_nxt;
            if_inst   <= if_inst_nxt;
            if_done   <= if_done_nxt;
            mem_rdata <= mem_rdata_nxt;
            mem_done  <= mem_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_mem)
                    state_nxt = mem_we ? MEM_WR : MEM_RD;
                else if (grant_if)
                    state_nxt = IF_RD;
            end
            IF_RD, MEM_RD: begin
                if (cnt == n_q + 3'd1)
                    state_nxt = IDLE;
            end
            MEM_WR: begin
                if (cnt == n_q)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cnt counts edges since the grant edge; reads lag their address by two edges.
    always_comb begin
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        buf_nxt       = buf_q;
        n_nxt         = n_q;
        cnt_nxt       = cnt;
        ram_a_nxt     = ram_a;
        ram_dout_nxt  = ram_dout;
        ram_wr_nxt    = ram_wr;
        if_inst_nxt   = if_inst;
        mem_rdata_nxt = mem_rdata;
        if_done_nxt   = 1'b0;
        mem_done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                ram_a_nxt    = '0;
                ram_dout_nxt = '0;
                ram_wr_nxt   = 1'b0;
                if (grant_mem || grant_if) begin
                    addr_nxt  = grant_mem ? mem_addr : if_addr;
                    n_nxt     = grant_mem ? len_bytes(mem_len) : 3'd4;
                    wdata_nxt = mem_wdata;
                    cnt_nxt   = 3'd1;
                    buf_nxt   = '0;
                    ram_a_nxt = grant_mem ? mem_addr : if_addr;
                    if (grant_mem && mem_we) begin
                        ram_wr_nxt   = 1'b1;
                        ram_dout_nxt = mem_wdata[7:0];
                    end
                end
            end
            IF_RD, MEM_RD: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt < n_q)
                    ram_a_nxt = addr_q + ADDR_W'(cnt);
                for (int unsigned i = 0; i < 4; i++) begin
                    if ({29'd0, cnt} == i + 2)
                        buf_nxt[8*i +: 8] = ram_din;
                end
                if (cnt == n_q + 3'd1) begin
                    ram_a_nxt = '0;
                    cnt_nxt   = '0;
                    if (state == IF_RD) begin
                        if_inst_nxt = buf_nxt;
                        if_done_nxt = 1'b1;
                    end else begin
                        mem_rdata_nxt = buf_nxt;
                        mem_done_nxt  = 1'b1;
                    end
                end
            end
            MEM_WR: begin
                if (cnt < n_q) begin
                    ram_a_nxt  = addr_q + ADDR_W'(cnt);
                    ram_wr_nxt = 1'b1;
                    cnt_nxt    = cnt + 3'd1;
                    for (int unsigned i = 0; i < 4; i++) begin
                        if ({29'd0, cnt} == i)
                            ram_dout_nxt = wdata_q[8*i +: 8];
                    end
                end else begin
                    ram_a_nxt    = '0;
                    ram_dout_nxt = '0;
                    ram_wr_nxt   = 1'b0;
                    mem_done_nxt = 1'b1;
                    cnt_nxt      = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random requesters,
// checked every cycle against a transaction-level model and a byte RAM.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_wdata = '0;
    logic [7:0]  ram_din = '0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [31:0] if_inst;
    logic        if_done;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stallreq_if;
    logic        stallreq_mem;

    logic [7:0]  ram [0:65535];
    int checks = 0;
    int errors = 0;
    int ed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .if_inst(if_inst), .if_done(if_done),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    // Synchronous RAM aliased on the low 16 address bits, read-before-write.
    always @(posedge clk) begin
        ram_din <= ram[ram_a[15:0]];
        if (ram_wr)
            ram[ram_a[15:0]] <= ram_dout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ed);
        end
    endtask

    // Transaction-level model: one transfer at a time, timed relative to its grant edge.
    typedef enum {T_NONE, T_IF, T_LD, T_ST} kind_t;
    kind_t       m_kind = T_NONE;
    int          m_t0 = 0;
    int          m_n = 0;
    int          last_done = -10;
    logic [31:0] m_addr = '0, m_wd = '0, m_data = '0;
    logic [31:0] e_ram_a = '0, e_if_inst = '0, e_mem_rdata = '0;
    logic [7:0]  e_dout = '0;
    logic        e_wr = 1'b0, e_ifd = 1'b0, e_memd = 1'b0, e_ld = 1'b0, e_a_care = 1'b1;

    task automatic model_step();
        int k;
        ed++;
        e_ifd  = 1'b0;
        e_memd = 1'b0;
        e_ld   = 1'b0;
        if (rst) begin
            m_kind = T_NONE; e_ram_a = '0; e_dout = '0; e_wr = 1'b0;
            e_if_inst = '0; e_mem_rdata = '0; e_a_care = 1'b1; last_done = -10;
        end else if (m_kind != T_NONE) begin
            k = ed - m_t0;
            e_a_care = 1'b1;
            if (m_kind == T_ST) begin
                if (k < m_n) begin
                    e_ram_a = m_addr + 32'(k); e_wr = 1'b1; e_dout = m_wd[8*k +: 8];
                end else begin
                    e_ram_a = '0; e_wr = 1'b0; e_dout = '0; e_memd = 1'b1;
                    m_kind = T_NONE; last_done = ed;
                end
            end else begin
                e_wr = 1'b0;
                e_dout = '0;
                if (k < m_n)
                    e_ram_a = m_addr + 32'(k);
                else if (k == m_n + 1) begin
                    e_ram_a = '0;
                    if (m_kind == T_IF) begin
                        e_ifd = 1'b1; e_if_inst = m_data;
                    end else begin
                        e_memd = 1'b1; e_ld = 1'b1; e_mem_rdata = m_data;
                    end
                    m_kind = T_NONE; last_done = ed;
                end else
                    e_a_care = 1'b0;
            end
        end else if (last_done != ed - 1 && (mem_req || if_req)) begin
            m_t0 = ed;
            e_a_care = 1'b1;
            if (mem_req) begin
                m_kind = mem_we ? T_ST : T_LD;
                m_addr = mem_addr;
                m_n = (mem_len == 2'd0) ? 1 : (mem_len == 2'd1) ? 2 : 4;
                m_wd = mem_wdata;
            end else begin
                m_kind = T_IF; m_addr = if_addr; m_n = 4; m_wd = '0;
            end
            m_data = '0;
            for (int i = 0; i < m_n; i++)
                m_data[8*i +: 8] = ram[16'(m_addr + 32'(i))];
            e_ram_a = m_addr;
            e_wr = (m_kind == T_ST);
            e_dout = (m_kind == T_ST) ? m_wd[7:0] : 8'h00;
        end else begin
            e_ram_a = '0; e_wr = 1'b0; e_dout = '0; e_a_care = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (e_a_care)
            chk("ram_a", ram_a, e_ram_a);
        chk("ram_wr", 32'(ram_wr), 32'(e_wr));
        chk("ram_dout", 32'(ram_dout), 32'(e_dout));
        chk("if_done", 32'(if_done), 32'(e_ifd));
        chk("mem_done", 32'(mem_done), 32'(e_memd));
        chk("if_inst", if_inst, e_if_inst);
        if (e_memd && e_ld)
            chk("mem_rdata", mem_rdata, e_mem_rdata);
        chk("stallreq_if", 32'(stallreq_if), 32'(if_req & ~e_ifd));
        chk("stallreq_mem", 32'(stallreq_mem), 32'(mem_req & ~e_memd));
    end

    task automatic wait_done(input bit is_mem, input int budget, output int at);
        at = -1;
        repeat (budget) begin
            @(negedge clk);
            if (is_mem ? mem_done : if_done) begin
                at = ed;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", is_mem ? "mem" : "if", budget);
        end
    endtask

    initial begin
        int e0, at;
        logic [7:0]  sb [4];
        logic [31:0] wrap_a [4];
        sb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wrap_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

        @(negedge clk);
        for (int i = 0; i < 65536; i++)
            ram[i] = 8'(i ^ (i >> 8) ^ 32'h5A);
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h00; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h2001] = 8'hCD; ram[16'h2002] = 8'hAB;
        ram[16'h0010] = 8'h77;
        repeat (2) @(negedge clk);
        chk("reset_ram_a", ram_a, 32'h0);
        chk("reset_ctl", {20'd0, ram_dout, ram_wr, if_done, mem_done, 1'b0}, 32'h0);
        chk("reset_if_inst", if_inst, 32'h0);
        chk("reset_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;

        // Fetch of a NOP word.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; e0 = ed + 1;
        wait_done(1'b0, 20, at);
        chk("fetch_latency", 32'(at - e0), 32'd5);
        chk("fetch_inst", if_inst, 32'h0000_0013);
        chk("fetch_stall_at_done", 32'(stallreq_if), 32'd0);
        if_req = 1'b0;

        // Half-word load across an odd address.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h2001; e0 = ed + 1;
        wait_done(1'b1, 20, at);
        chk("ldh_latency", 32'(at - e0), 32'd3);
        chk("ldh_data", mem_rdata, 32'h0000_ABCD);
        mem_req = 1'b0;

        // Word store, little-endian byte order.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h3000; mem_wdata = 32'hDEAD_BEEF;
        e0 = ed + 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_addr", ram_a, 32'h3000 + 32'(i));
            chk("st_byte", {23'd0, ram_wr, ram_dout}, {23'd0, 1'b1, sb[i]});
        end
        wait_done(1'b1, 20, at);
        chk("st_latency", 32'(at - e0), 32'd4);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("st_ram", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'hDEAD_BEEF);

        // Simultaneous requests: load byte first, fetch after.
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h10;
        e0 = ed + 1;
        wait_done(1'b1, 20, at);
        chk("both_mem_latency", 32'(at - e0), 32'd2);
        chk("both_mem_data", mem_rdata, 32'h0000_0077);
        chk("both_if_stalled", 32'(stallreq_if), 32'd1);
        mem_req = 1'b0;
        wait_done(1'b0, 20, at);
        chk("both_if_latency", 32'(at - e0), 32'd9);
        chk("both_if_inst", if_inst, 32'h0000_0013);
        if_req = 1'b0;

        // Address wrap at the top of the space.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrap_addr", ram_a, wrap_a[i]);
        end
        wait_done(1'b0, 20, at);
        chk("wrap_inst", if_inst, {ram[16'h0001], ram[16'h0000], ram[16'hFFFF], ram[16'hFFFE]});
        if_req = 1'b0;

        // Reset at the third edge of a word store.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h4000; mem_wdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctl", {20'd0, ram_dout, ram_wr, if_done, mem_done, 1'b0}, 32'h0);
        chk("rst_mid_ram_a", ram_a, 32'h0);
        chk("rst_mid_if_inst", if_inst, 32'h0);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("rst_no_activity", {30'd0, mem_done, ram_wr}, 32'h0);
        end
        if_req = 1'b1; if_addr = 32'h100; e0 = ed + 1;
        wait_done(1'b0, 20, at);
        chk("post_rst_latency", 32'(at - e0), 32'd5);
        chk("post_rst_inst", if_inst, 32'h0000_0013);
        if_req = 1'b0;

        // Random requesters with flushes and input churn.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (if_req && if_done)
                if_req = 1'b0;
            else if (if_req && $urandom_range(0, 39) == 0)
                if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = $urandom;
            end
            if (if_req && $urandom_range(0, 9) == 0)
                if_addr = $urandom;
            if (mem_req && mem_done)
                mem_req = 1'b0;
            else if (mem_req && $urandom_range(0, 39) == 0)
                mem_req = 1'b0;
            else if (!mem_req && $urandom_range(0, 3) == 0) begin
                mem_req = 1'b1;
                mem_we = 1'($urandom_range(0, 1));
                mem_len = 2'($urandom_range(0, 3));
                mem_addr = $urandom;
                mem_wdata = $urandom;
            end
            if (mem_req && $urandom_range(0, 9) == 0) begin
                mem_addr = $urandom;
                mem_wdata = $urandom;
                mem_len = 2'($urandom_range(0, 3));
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
